// File: rtl/reg_file_dump_pkg.sv
// Shared constants for the 8x8 register file and its debug dump sequencer.
package reg_file_dump_pkg;
    localparam int unsigned DATA_W_DFLT = 8;
    localparam int unsigned ADDR_W_DFLT = 3;
    localparam int unsigned NREG        = 2 ** ADDR_W_DFLT;

    // Legacy state encodings kept as plain constants so existing trace decoders still match.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/reg_file_dump_dff_nbit_arst.sv
// W-bit register with load enable and asynchronous active-high clear to zero.
module dff_nbit_arst #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= '0;
        end else if (EN) begin
            Q <= D;
        end
    end
endmodule

// File: rtl/reg_file_dump.sv
// CPU register file (1 write, 2 bypassed read ports) with a valid/ready debug dump
// sequencer that streams every register out in index order.
module reg_file_dump
    import reg_file_dump_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned ADDR_W = ADDR_W_DFLT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [ADDR_W-1:0] RADDR_A,
    output logic [DATA_W-1:0] RDATA_A,
    input  logic [ADDR_W-1:0] RADDR_B,
    output logic [DATA_W-1:0] RDATA_B,
    input  logic              DUMP_REQ,
    input  logic              DUMP_READY,
    output logic              DUMP_VALID,
    output logic [ADDR_W-1:0] DUMP_ADDR,
    output logic [DATA_W-1:0] DUMP_DATA,
    output logic              DUMP_BUSY,
    output logic              DUMP_DONE
);
    localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        dff_nbit_arst #(.W(DATA_W)) u_reg (
            .CLK (CLK),
            .RST (RST),
            .EN  (WE && (WADDR == ADDR_W'(i))),
            .D   (WDATA),
            .Q   (regs_q[i])
        );
    end

    assign RDATA_A = (WE && (WADDR == RADDR_A)) ? WDATA : regs_q[RADDR_A];
    assign RDATA_B = (WE && (WADDR == RADDR_B)) ? WDATA : regs_q[RADDR_B];

    // The snapshot goes through the same bypass so a write on the load edge is captured.
    assign load_data = (WE && (WADDR == load_addr)) ? WDATA : regs_q[load_addr];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        load_en   = 1'b0;
        load_addr = ptr_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (DUMP_REQ) begin
                    state_d   = SEND;
                    ptr_d     = '0;
                    load_en   = 1'b1;
                    load_addr = '0;
                end
            end
            SEND: begin
                if (DUMP_READY) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        load_en = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    dff_nbit_arst #(.W(DATA_W)) u_dump_data (
        .CLK (CLK),
        .RST (RST),
        .EN  (load_en),
        .D   (load_data),
        .Q   (DUMP_DATA)
    );

    assign DUMP_VALID = (state_q == SEND);
    assign DUMP_BUSY  = (state_q != IDLE);
    assign DUMP_DONE  = (state_q == DONE);
    assign DUMP_ADDR  = ptr_q;
endmodule

// File: tb/tb_reg_file_dump.sv
// Scoreboard bench for reg_file_dump: directed writes/reads plus dump beats checked by a monitor.
module tb_reg_file_dump;
    logic       CLK, RST, WE, DUMP_REQ, DUMP_READY;
    logic [2:0] WADDR, RADDR_A, RADDR_B;
    logic [7:0] WDATA, RDATA_A, RDATA_B;
    logic       DUMP_VALID, DUMP_BUSY, DUMP_DONE;
    logic [2:0] DUMP_ADDR;
    logic [7:0] DUMP_DATA;

    reg_file_dump #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WE         (WE),
        .WADDR      (WADDR),
        .WDATA      (WDATA),
        .RADDR_A    (RADDR_A),
        .RDATA_A    (RDATA_A),
        .RADDR_B    (RADDR_B),
        .RDATA_B    (RDATA_B),
        .DUMP_REQ   (DUMP_REQ),
        .DUMP_READY (DUMP_READY),
        .DUMP_VALID (DUMP_VALID),
        .DUMP_ADDR  (DUMP_ADDR),
        .DUMP_DATA  (DUMP_DATA),
        .DUMP_BUSY  (DUMP_BUSY),
        .DUMP_DONE  (DUMP_DONE)
    );

    typedef struct {
        bit         is_done;
        logic [2:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    logic [7:0] mdl[8];
    int         compares = 0;
    int         fails    = 0;
    int         cyc;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WE = 1'b1; WADDR = a; WDATA = d;
        tick();
        WE = 1'b0;
        mdl[a] = d;
    endtask

    task automatic push_dump(input int nbeats, input bit with_done);
        exp_t e;
        for (int i = 0; i < nbeats; i++) begin
            e.is_done = 1'b0; e.addr = 3'(i); e.data = mdl[i];
            sbq.push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1; e.addr = '0; e.data = '0;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_idle(input int maxc, output int cycles);
        cycles = 0;
        while (DUMP_BUSY && cycles < maxc) begin
            tick();
            cycles++;
        end
        if (DUMP_BUSY) begin
            compares++;
            fails++;
            $display("FAIL wait_idle_timeout: got busy after %0d cycles expected idle", cycles);
        end
    endtask

    task automatic clear_mdl();
        for (int i = 0; i < 8; i++) mdl[i] = '0;
    endtask

    // Monitor: every accepted beat and every DONE cycle consumes one scoreboard entry.
    always @(negedge CLK) begin
        if (DUMP_VALID && DUMP_READY) begin
            compares++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: got addr %0d data %0h expected nothing", DUMP_ADDR, DUMP_DATA);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.is_done || DUMP_ADDR !== mon_e.addr || DUMP_DATA !== mon_e.data) begin
                    fails++;
                    $display("FAIL beat: got addr %0d data %0h expected addr %0d data %0h done=%0d",
                             DUMP_ADDR, DUMP_DATA, mon_e.addr, mon_e.data, mon_e.is_done);
                end
            end
        end
        if (DUMP_DONE) begin
            compares++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: got DONE expected nothing");
            end else begin
                mon_e = sbq.pop_front();
                if (!mon_e.is_done) begin
                    fails++;
                    $display("FAIL done_early: got DONE expected beat addr %0d data %0h", mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; WE = 1'b0; WADDR = '0; WDATA = '0;
        RADDR_A = '0; RADDR_B = '0; DUMP_REQ = 1'b0; DUMP_READY = 1'b0;
        clear_mdl();
        tick(); tick();
        RST = 1'b0;
        #1;
        chk("rst_valid", DUMP_VALID, 0);
        chk("rst_busy", DUMP_BUSY, 0);
        chk("rst_done", DUMP_DONE, 0);
        chk("rst_addr", DUMP_ADDR, 0);
        chk("rst_data", DUMP_DATA, 0);
        chk("rst_rdata", RDATA_A, 0);

        // Asynchronous reset mid-cycle while a dump is in progress
        wr(3'd1, 8'h55);
        RADDR_A = 3'd1;
        DUMP_REQ = 1'b1;
        tick();
        DUMP_REQ = 1'b0;
        chk("pre_rst_busy", DUMP_BUSY, 1);
        chk("pre_rst_valid", DUMP_VALID, 1);
        chk("pre_rst_rdata", RDATA_A, 8'h55);
        RST = 1'b1;
        #1;
        chk("arst_rdata", RDATA_A, 0);
        chk("arst_valid", DUMP_VALID, 0);
        chk("arst_busy", DUMP_BUSY, 0);
        chk("arst_done", DUMP_DONE, 0);
        clear_mdl();
        tick();
        RST = 1'b0;

        // Write then read both ports, then same-cycle bypass
        wr(3'd3, 8'hA5);
        RADDR_A = 3'd3; RADDR_B = 3'd3;
        #1;
        chk("rd_a_r3", RDATA_A, 8'hA5);
        chk("rd_b_r3", RDATA_B, 8'hA5);
        WE = 1'b1; WADDR = 3'd5; WDATA = 8'h3C; RADDR_A = 3'd5;
        #1;
        chk("bypass_a", RDATA_A, 8'h3C);
        chk("no_bypass_b", RDATA_B, 8'hA5);
        tick();
        WE = 1'b0;
        mdl[5] = 8'h3C;
        #1;
        chk("stored_r5", RDATA_A, 8'h3C);

        // Full dump with READY held high
        for (int n = 0; n < 8; n++) wr(3'(n), 8'h10 + 8'(n));
        RADDR_B = 3'd0;
        #1;
        chk("rd_b_r0", RDATA_B, 8'h10);
        push_dump(8, 1'b1);
        DUMP_READY = 1'b1;
        DUMP_REQ = 1'b1;
        tick();
        DUMP_REQ = 1'b0;
        wait_idle(30, cyc);
        chk("dump_cycles", cyc, 9);
        chk("dump_done_low", DUMP_DONE, 0);

        // Backpressure on beat 2 with a write to r2 during the stall
        push_dump(8, 1'b1);
        DUMP_REQ = 1'b1;
        tick();
        DUMP_REQ = 1'b0;
        tick(); tick();
        DUMP_READY = 1'b0;
        chk("stall_addr", DUMP_ADDR, 2);
        WE = 1'b1; WADDR = 3'd2; WDATA = 8'hFF;
        tick();
        WE = 1'b0;
        mdl[2] = 8'hFF;
        chk("stall_hold_data", DUMP_DATA, 8'h12);
        chk("stall_hold_valid", DUMP_VALID, 1);
        tick();
        chk("stall_hold_addr", DUMP_ADDR, 2);
        chk("stall_hold_data2", DUMP_DATA, 8'h12);
        DUMP_READY = 1'b1;
        wait_idle(30, cyc);
        RADDR_A = 3'd2;
        #1;
        chk("r2_after_stall", RDATA_A, 8'hFF);

        // REQ held high: second dump only after one IDLE cycle
        push_dump(8, 1'b1);
        push_dump(8, 1'b1);
        DUMP_REQ = 1'b1;
        tick();
        wait_idle(30, cyc);
        chk("held_req_cycles", cyc, 9);
        chk("held_req_gap", DUMP_BUSY, 0);
        tick();
        chk("held_req_restart", DUMP_BUSY, 1);
        chk("held_req_addr0", DUMP_ADDR, 0);
        DUMP_REQ = 1'b0;
        wait_idle(30, cyc);
        chk("second_dump_cycles", cyc, 9);

        // Reset during beat 4 aborts the dump
        push_dump(4, 1'b0);
        DUMP_REQ = 1'b1;
        tick();
        DUMP_REQ = 1'b0;
        tick(); tick(); tick(); tick();
        chk("beat4_addr", DUMP_ADDR, 4);
        RST = 1'b1;
        #1;
        chk("abort_valid", DUMP_VALID, 0);
        chk("abort_busy", DUMP_BUSY, 0);
        chk("abort_done", DUMP_DONE, 0);
        chk("abort_addr", DUMP_ADDR, 0);
        chk("abort_data", DUMP_DATA, 0);
        chk("abort_regs", RDATA_A, 0);
        clear_mdl();
        tick();
        RST = 1'b0;
        tick(); tick(); tick();
        chk("abort_stays_idle", DUMP_BUSY, 0);

        // Restart from addr 0; beat 0 snapshot includes a write on the load edge
        wr(3'd7, 8'h88);
        mdl[0] = 8'h99;
        push_dump(8, 1'b1);
        WE = 1'b1; WADDR = 3'd0; WDATA = 8'h99;
        DUMP_REQ = 1'b1;
        tick();
        WE = 1'b0;
        DUMP_REQ = 1'b0;
        chk("restart_addr0", DUMP_ADDR, 0);
        wait_idle(30, cyc);
        tick();
        chk("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
